// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped reload timer: register offsets,
// TCON bit positions, the default base address and the address decoder.
package timer_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets of the registers inside the 16-byte window.
  localparam logic [3:0] TH_OFF   = 4'h0;
  localparam logic [3:0] TL_OFF   = 4'h4;
  localparam logic [3:0] TCON_OFF = 4'h8;

  // TCON bit positions as seen on the bus.
  localparam int EN_BIT     = 0;
  localparam int IE_BIT     = 1;
  localparam int STATUS_BIT = 2;
  localparam int MISSED_BIT = 3;

  // Which register (if any) an access selects.
  typedef enum logic [1:0] {
    REG_TH   = 2'b00,
    REG_TL   = 2'b01,
    REG_TCON = 2'b10,
    REG_NONE = 2'b11
  } reg_sel_e;

  // Packed so that the member order matches the TCON bit positions:
  // missed=[3], status=[2], ie=[1], en=[0].
  typedef struct packed {
    logic missed;
    logic status;
    logic ie;
    logic en;
  } tcon_t;

  // Map a byte address to a register select. Byte lanes are ignored and
  // offset 0xC inside the window is treated as a miss.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[31:4] == base[31:4]) begin
      case ({addr[3:2], 2'b00})
        TH_OFF:   sel = REG_TH;
        TL_OFF:   sel = REG_TL;
        TCON_OFF: sel = REG_TCON;
        default:  sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

  // TCON as a 32-bit bus word; the upper bits always read 0.
  function automatic logic [31:0] tcon_word(input tcon_t t);
    return {28'd0, t};
  endfunction

endpackage

// File: rtl/timer_irq_source_tick_gen.sv
// Counter prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// The phase counter is held at zero while disabled, so re-enabling always
// yields a full PRESCALE-cycle interval before the first tick.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    // Every enabled cycle is a tick; no state needed.
    assign tick = en;

    logic unused_ports;
    assign unused_ports = clk ^ reset;
  end else begin : g_div
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next phase: clear while disabled, wrap after LAST, else advance.
    // NOTE: every always_comb output gets a default on entry so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Phase register with synchronous reset.
    // NOTE: flops use non-blocking assignment so all registers sample the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign tick = en && (cnt_q == LAST);
  end

endmodule

// File: rtl/timer_irq_source.sv
// 32-bit reload timer on the data-memory bus. Counts up from TL on each
// prescaled tick, reloads from TH on overflow and raises IRQ (IE & STATUS)
// for the control unit. STATUS is acknowledged by write-1-to-clear; an
// overflow arriving while STATUS is still pending is recorded in MISSED.
module timer_irq_source
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  // Architectural state.
  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  tcon_t       tcon_q, tcon_d;
  logic        irq_q, irq_d;

  // Decode and per-register write strobes.
  reg_sel_e sel;
  logic     wr_th, wr_tl, wr_tcon;
  logic     clr_status;

  assign sel        = decode_addr(Address, BASE_ADDR);
  assign wr_th      = MemWrite && (sel == REG_TH);
  assign wr_tl      = MemWrite && (sel == REG_TL);
  assign wr_tcon    = MemWrite && (sel == REG_TCON);
  assign clr_status = wr_tcon && WriteData[STATUS_BIT];

  // Reads have no side effects and byte lanes are ignored.
  logic unused_bus;
  assign unused_bus = ^{Address[1:0], MemRead};

  // Prescaled tick, running only while EN is set. A TCON write that clears
  // EN still sees this cycle's tick because the prescaler uses EN as held.
  logic tick;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_q.en),
    .tick  (tick)
  );

  // Overflow happens on a tick at all-ones, unless a TL write in the same
  // cycle takes precedence, in which case the tick is discarded entirely.
  logic tl_max, ovf;
  assign tl_max = (tl_q == 32'hFFFF_FFFF);
  assign ovf    = tick && tl_max && !wr_tl;

  // TH is only changed by software.
  always_comb begin
    th_d = th_q;
    if (wr_th) begin
      th_d = WriteData;
    end
  end

  // TL: bus write wins over counting; reload uses the pre-edge TH so a TH
  // write coinciding with overflow takes effect on the next reload.
  always_comb begin
    tl_d = tl_q;
    if (wr_tl) begin
      tl_d = WriteData;
    end else if (tick) begin
      tl_d = tl_max ? th_q : tl_q + 32'd1;
    end
  end

  // TCON: software updates first, then the overflow event on top so a
  // simultaneous acknowledge can never swallow a new interrupt.
  always_comb begin
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d.en = WriteData[EN_BIT];
      tcon_d.ie = WriteData[IE_BIT];
      if (WriteData[STATUS_BIT]) begin
        tcon_d.status = 1'b0;
      end
      if (WriteData[MISSED_BIT]) begin
        tcon_d.missed = 1'b0;
      end
    end
    if (ovf && tcon_q.ie) begin
      // Still pending and not being acknowledged: this one is lost.
      if (tcon_q.status && !clr_status) begin
        tcon_d.missed = 1'b1;
      end
      tcon_d.status = 1'b1;
    end
  end

  // IRQ is registered from the next-state bits so it is glitch-free and
  // changes on the same edge as STATUS/IE.
  always_comb begin
    irq_d = tcon_d.ie & tcon_d.status;
  end

  // State registers; a synchronous reset clears everything at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      irq_q  <= irq_d;
    end
  end

  // Combinational read mux, driven on any hit regardless of MemRead.
  always_comb begin
    ReadData = 32'd0;
    case (sel)
      REG_TH:   ReadData = th_q;
      REG_TL:   ReadData = tl_q;
      REG_TCON: ReadData = tcon_word(tcon_q);
      default:  ReadData = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source: one instance with PRESCALE=1 at the default
// base and one with PRESCALE=4 at base+0x10, sharing one bus. A behavioural
// model of each timer is compared against IRQ and ReadData every cycle;
// directed steps add hand-computed literal expectations.
module tb_timer_irq_source;

  localparam logic [31:0] B1 = 32'h4000_0000;
  localparam logic [31:0] B4 = 32'h4000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4;

  always #5 clk = ~clk;

  timer_irq_source #(
    .BASE_ADDR (B1),
    .PRESCALE  (1)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (rd1),
    .IRQ       (irq1)
  );

  timer_irq_source #(
    .BASE_ADDR (B4),
    .PRESCALE  (4)
  ) dut4 (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (rd4),
    .IRQ       (irq4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] th;
    logic [31:0] tl;
    bit          en;
    bit          ie;
    bit          st;
    bit          mi;
    int          ph;   // enabled cycles elapsed since the last tick
  } mstate_t;

  function automatic mstate_t mstep(input mstate_t s, input int pre,
                                    input logic [31:0] base, input logic rst,
                                    input logic we, input logic [31:0] a,
                                    input logic [31:0] wd);
    mstate_t n;
    bit tick, ovf, hit;
    n = s;
    if (rst) begin
      n.th = 0; n.tl = 0; n.en = 0; n.ie = 0; n.st = 0; n.mi = 0; n.ph = 0;
      return n;
    end
    hit  = (a[31:4] == base[31:4]) && (a[3:2] != 2'b11);
    tick = s.en && (s.ph == pre - 1);
    n.ph = (s.en && !tick) ? s.ph + 1 : 0;
    ovf  = tick && (s.tl == 32'hFFFF_FFFF);
    if (tick) n.tl = ovf ? s.th : s.tl + 32'd1;
    if (we && hit) begin
      case (a[3:2])
        2'b00: n.th = wd;
        2'b01: begin n.tl = wd; ovf = 1'b0; end
        2'b10: begin
          n.en = wd[0];
          n.ie = wd[1];
          if (wd[2]) n.st = 1'b0;
          if (wd[3]) n.mi = 1'b0;
        end
        default: ;
      endcase
    end
    if (ovf && s.ie) begin
      // Pending and not acknowledged this cycle means the new one is lost.
      if (n.st) n.mi = 1'b1;
      n.st = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [31:0] mread(input mstate_t s,
                                        input logic [31:0] base,
                                        input logic [31:0] a);
    if (a[31:4] != base[31:4]) return 32'd0;
    case (a[3:2])
      2'b00:   return s.th;
      2'b01:   return s.tl;
      2'b10:   return {28'd0, s.mi, s.st, s.ie, s.en};
      default: return 32'd0;
    endcase
  endfunction

  mstate_t m1, m4;
  bit started = 1'b0;

  always @(posedge clk) begin
    m1 <= mstep(m1, 1, B1, reset, MemWrite, Address, WriteData);
    m4 <= mstep(m4, 4, B4, reset, MemWrite, Address, WriteData);
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("model_irq1", {31'd0, irq1}, {31'd0, m1.ie & m1.st});
      check("model_irq4", {31'd0, irq4}, {31'd0, m4.ie & m4.st});
      check("model_rd1", rd1, mread(m1, B1, Address));
      check("model_rd4", rd4, mread(m4, B4, Address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus write that takes effect at the next rising edge.
  task automatic write(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  // Timing-neutral read of whichever instance owns the address.
  task automatic peek(input string name, input logic [31:0] a,
                      input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    check(name, a[4] ? rd4 : rd1, exp);
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    peek("rst_th", B1 + 32'h0, 32'h0);
    peek("rst_tl", B1 + 32'h4, 32'h0);
    peek("rst_tcon", B1 + 32'h8, 32'h0);
    peek("rst_off_c", B1 + 32'hC, 32'h0);
    check("rst_irq1", {31'd0, irq1}, 32'h0);
    check("rst_irq4", {31'd0, irq4}, 32'h0);
    wait_edges(1);
    peek("rst4_tl", B4 + 32'h4, 32'h0);
    peek("rst4_tcon", B4 + 32'h8, 32'h0);

    // PRESCALE=4: EN at edge m, increments at m+4, m+8.
    write(B4 + 32'h4, 32'h0);
    write(B4 + 32'h8, 32'h1);
    wait_edges(3);
    peek("p4_tl_m3", B4 + 32'h4, 32'h0);
    wait_edges(1);
    peek("p4_tl_m4", B4 + 32'h4, 32'h1);
    wait_edges(3);
    peek("p4_tl_m7", B4 + 32'h4, 32'h1);
    wait_edges(1);
    peek("p4_tl_m8", B4 + 32'h4, 32'h2);
    write(B4 + 32'h8, 32'h0);
    wait_edges(2);
    write(B4 + 32'h8, 32'h1);
    peek("p4_reen_0", B4 + 32'h4, 32'h2);
    wait_edges(3);
    peek("p4_reen_3", B4 + 32'h4, 32'h2);
    wait_edges(1);
    peek("p4_reen_4", B4 + 32'h4, 32'h3);

    // PRESCALE=1 overflow: TCON=3 at edge k, IRQ at k+4 with reload.
    write(B1 + 32'h0, 32'hFFFF_FFFC);
    write(B1 + 32'h4, 32'hFFFF_FFFC);
    write(B1 + 32'h8, 32'h3);
    peek("ovf_tl_k0", B1 + 32'h4, 32'hFFFF_FFFC);
    for (int i = 1; i <= 4; i++) begin
      logic [31:0] e;
      wait_edges(1);
      e = (i == 4) ? 32'hFFFF_FFFC : 32'hFFFF_FFFC + 32'(i);
      peek($sformatf("ovf_tl_k%0d", i), B1 + 32'h4, e);
      check($sformatf("ovf_irq_k%0d", i), {31'd0, irq1}, (i == 4) ? 32'h1 : 32'h0);
    end
    wait_edges(4);
    peek("missed_tcon", B1 + 32'h8, 32'hF);
    check("missed_irq", {31'd0, irq1}, 32'h1);

    // Acknowledge handling.
    write(B1 + 32'h8, 32'h3);
    peek("ack3_tcon", B1 + 32'h8, 32'hF);
    write(B1 + 32'h8, 32'h7);
    peek("ack7_tcon", B1 + 32'h8, 32'hB);
    check("ack7_irq", {31'd0, irq1}, 32'h0);
    write(B1 + 32'h8, 32'hB);
    peek("clrmiss_tcon", B1 + 32'h8, 32'h3);
    peek("clrmiss_tl", B1 + 32'h4, 32'hFFFF_FFFF);
    wait_edges(1);
    peek("reovf_tcon", B1 + 32'h8, 32'h7);
    peek("reovf_tl", B1 + 32'h4, 32'hFFFF_FFFC);

    // W1C on the overflow edge: set wins, nothing missed.
    wait_edges(3);
    write(B1 + 32'h8, 32'h7);
    peek("w1c_ovf_tcon", B1 + 32'h8, 32'h7);
    peek("w1c_ovf_tl", B1 + 32'h4, 32'hFFFF_FFFC);
    check("w1c_ovf_irq", {31'd0, irq1}, 32'h1);

    // TL write on the would-be overflow edge: write wins, no interrupt.
    write(B1 + 32'h8, 32'h7);
    peek("ack_tcon", B1 + 32'h8, 32'h3);
    wait_edges(2);
    peek("pre_tlwr_tl", B1 + 32'h4, 32'hFFFF_FFFF);
    write(B1 + 32'h4, 32'h10);
    peek("tlwr_tl", B1 + 32'h4, 32'h10);
    peek("tlwr_tcon", B1 + 32'h8, 32'h3);
    check("tlwr_irq", {31'd0, irq1}, 32'h0);
    wait_edges(1);
    peek("tlwr_next", B1 + 32'h4, 32'h11);

    // TH write on overflow edge: reload uses the old TH.
    write(B1 + 32'h4, 32'hFFFF_FFFF);
    write(B1 + 32'h0, 32'h55);
    peek("thwr_tl", B1 + 32'h4, 32'hFFFF_FFFC);
    peek("thwr_th", B1 + 32'h0, 32'h55);
    peek("thwr_tcon", B1 + 32'h8, 32'h7);
    check("thwr_irq", {31'd0, irq1}, 32'h1);

    // One-cycle reset while IRQ is high and both timers count.
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    peek("mrst_th", B1 + 32'h0, 32'h0);
    peek("mrst_tl", B1 + 32'h4, 32'h0);
    peek("mrst_tcon", B1 + 32'h8, 32'h0);
    check("mrst_irq1", {31'd0, irq1}, 32'h0);
    wait_edges(1);
    peek("mrst4_tl", B4 + 32'h4, 32'h0);
    check("mrst_irq4", {31'd0, irq4}, 32'h0);
    wait_edges(3);
    peek("hold_tl1", B1 + 32'h4, 32'h0);
    peek("hold_tl4", B4 + 32'h4, 32'h0);

    MemRead = 1'b0;
    wait_edges(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
